match_ctrl: RTL and testbench
=============================

MATCH_CTRL -- requirements
Module: match_ctrl

Interface
REQ-001 Parameter WIN_POINTS, default 9: score that ends a match; legal range 1..15.
REQ-002 Parameter POINT_HOLD, default 2: number of tick pulses spent in POINT before the next serve or game over.
REQ-003 Parameter SERVE_DELAY, default 1: number of tick pulses spent in SERVE before the ball is released.
REQ-004 CLOCK_50  in  1  sole clock; every flop updates on its rising edge.
REQ-005 rst_n  in  1  reset; synchronous and active-low.
REQ-006 tick  in  1  game-rate strobe, one CLOCK_50 cycle wide.
REQ-007 start_n  in  1  raw start key, active-low, asynchronous to CLOCK_50.
REQ-008 dir_rand  in  1  random serve direction from the LFSR.
REQ-009 miss_l  in  1  one-cycle pulse: ball passed the left paddle, so the point goes to player 2.
REQ-010 miss_r  in  1  one-cycle pulse: ball passed the right paddle, so the point goes to player 1.
REQ-011 run  out  1  ball-motion enable; high only in PLAY.
REQ-012 serve  out  1  one-cycle pulse that releases the ball.
REQ-013 serve_dir  out  1  direction of the ball at serve: 0 = toward player 1, 1 = toward player 2.
REQ-014 score1, score2  out  4 each  player scores.
REQ-015 winner  out  2  match result: 00 = none, 01 = player 1, 10 = player 2.
REQ-016 state  out  3  current state encoding, for the HEX display and debug.

Function
REQ-017 The state machine SHALL have five states: IDLE, SERVE, PLAY, POINT, OVER.
REQ-018 start_n SHALL pass through a 2-flop synchronizer; one falling edge after synchronization SHALL produce a single-cycle start event, so worst-case latency is 3 cycles.
REQ-019 IDLE + start event -> SERVE: clear both scores, latch serve_dir = dir_rand, clear the tick counter.
REQ-020 SERVE SHALL count tick pulses. On the tick that brings the count to SERVE_DELAY, the block SHALL assert serve for that cycle only, enter PLAY, and clear the counter.
REQ-021 PLAY + miss_r alone -> POINT, score1 +1, serve_dir = 1 (next serve goes toward the player who lost the point).
REQ-022 PLAY + miss_l alone -> POINT, score2 +1, serve_dir = 0.
REQ-023 PLAY + miss_l and miss_r in the same cycle -> POINT with no score change and serve_dir = dir_rand (a let).
REQ-024 POINT SHALL count tick pulses. On the POINT_HOLD-th tick: if either score equals WIN_POINTS, go to OVER; otherwise go to SERVE.
REQ-025 OVER: winner SHALL reflect whichever score equals WIN_POINTS. A start event in OVER SHALL behave exactly like REQ-019 and clear winner.
REQ-026 The block SHALL ignore misses outside PLAY, start events outside IDLE and OVER, and ticks in IDLE, PLAY and OVER.
REQ-027 Scores SHALL saturate at WIN_POINTS and never wrap, so increments past WIN_POINTS have no effect.
REQ-028 Scores SHALL change only on the PLAY->POINT transition; winner SHALL change only on entry to OVER and on start.
REQ-029 Outputs SHALL be registered; serve and run SHALL switch in the same cycle as the state register.
REQ-030 A miss pulse coincident with the SERVE->PLAY cycle SHALL be ignored, because the block samples it in SERVE.

Reset
REQ-031 rst_n = 0 at a rising edge SHALL force: state = IDLE, run = 0, serve = 0, serve_dir = 0, score1 = 0, score2 = 0, winner = 00, tick counter = 0, synchronizer flops = 1 (key released).
REQ-032 Reset asserted mid-match SHALL abandon the match with no partial update; reset SHALL take priority over every other event in the same cycle.
REQ-033 Leaving reset SHALL NOT generate a start event while start_n is held low. A release followed by a new press is required.

Structure
REQ-034 A shared include, pong_defs, SHALL hold the state encodings, the winner codes and the 4-bit score width, and the ball and display blocks SHALL use it too.
REQ-035 The synchronizer plus falling-edge detector SHALL be a sub-module named key_edge, reusable for the other KEY inputs.
REQ-036 The tick counter SHALL be 4 bits wide, shared between SERVE and POINT, and cleared on every state change.

Verification
REQ-037 Reset, press start, SERVE_DELAY=1 -> SERVE within 3 cycles; serve pulses for exactly 1 cycle on the next tick; run = 1 afterwards.
REQ-038 In PLAY, pulse miss_r -> score1 = 1, serve_dir = 1, run = 0; after 2 ticks -> SERVE.
REQ-039 WIN_POINTS=3, inject 3 miss_l pulses across three rallies -> score2 = 3, OVER after POINT_HOLD ticks, winner = 10; a further miss_l leaves score2 at 3.
REQ-040 miss_l and miss_r in the same PLAY cycle -> no score change, POINT, serve_dir equals dir_rand.
REQ-041 Drop rst_n mid-PLAY with score1 = 2 -> next cycle all outputs are at reset values; start held low through reset release -> stays in IDLE until start is released and pressed again.
REQ-042 Press start in OVER -> scores = 0, winner = 00, SERVE; miss pulses sent in SERVE and POINT -> scores unchanged.

Source files
------------

// File: rtl/match_ctrl_pkg.sv
// Shared definitions for the pong match controller: state encodings,
// winner codes, score width and the saturating score helper.
package match_ctrl_pkg;

  localparam int SCORE_W = 4;
  localparam int CNT_W   = 4;

  typedef logic [SCORE_W-1:0] score_t;
  typedef logic [CNT_W-1:0]   tick_cnt_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  localparam logic [1:0] WINNER_NONE = 2'b00;
  localparam logic [1:0] WINNER_P1   = 2'b01;
  localparam logic [1:0] WINNER_P2   = 2'b10;

  // Scores stop at the match limit instead of wrapping.
  function automatic score_t score_inc(input score_t s, input score_t limit);
    score_inc = (s < limit) ? s + score_t'(1) : s;
  endfunction

  function automatic logic [1:0] winner_code(input score_t s1, input score_t s2,
                                             input score_t limit);
    if (s1 == limit)
      winner_code = WINNER_P1;
    else if (s2 == limit)
      winner_code = WINNER_P2;
    else
      winner_code = WINNER_NONE;
  endfunction

endpackage

// File: rtl/match_ctrl_if.sv
// Game-side signal bundle of the match controller; the slave modport is
// the controller, the master modport is whatever feeds it.
interface match_ctrl_if;
  import match_ctrl_pkg::*;

  logic       tick;
  logic       start_n;
  logic       dir_rand;
  logic       miss_l;
  logic       miss_r;
  logic       run;
  logic       serve;
  logic       serve_dir;
  score_t     score1;
  score_t     score2;
  logic [1:0] winner;
  logic [2:0] state;

  modport master (
    output tick, start_n, dir_rand, miss_l, miss_r,
    input  run, serve, serve_dir, score1, score2, winner, state
  );

  modport slave (
    input  tick, start_n, dir_rand, miss_l, miss_r,
    output run, serve, serve_dir, score1, score2, winner, state
  );

endinterface

// File: rtl/key_edge.sv
// Two-flop synchronizer plus falling-edge detector for an active-low key.
// A press only counts after a released level has been seen since reset.
module key_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic fall
);

  logic       meta_reg;
  logic       sync_reg;
  logic       prev_reg;
  logic [1:0] fill_reg;
  logic       armed_reg;

  // fill_reg tracks when sync_reg holds a real post-reset sample; the
  // forced-high reset values must not be mistaken for a release.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_reg  <= 1'b1;
      sync_reg  <= 1'b1;
      prev_reg  <= 1'b1;
      fill_reg  <= 2'b00;
      armed_reg <= 1'b0;
    end else begin
      meta_reg  <= key_n;
      sync_reg  <= meta_reg;
      prev_reg  <= sync_reg;
      fill_reg  <= {fill_reg[0], 1'b1};
      armed_reg <= armed_reg | (fill_reg[1] & sync_reg);
    end
  end

  assign fall = armed_reg & prev_reg & ~sync_reg;

endmodule

// File: rtl/match_ctrl.sv
// Pong match sequencer: IDLE -> SERVE -> PLAY -> POINT -> (SERVE | OVER),
// keeping score and choosing the serve direction.
module match_ctrl
  import match_ctrl_pkg::*;
#(
  parameter int WIN_POINTS  = 9,
  parameter int POINT_HOLD  = 2,
  parameter int SERVE_DELAY = 1
) (
  input  logic         CLOCK_50,
  input  logic         rst_n,
  match_ctrl_if.slave  bus
);

  localparam score_t    WIN_SCORE  = score_t'(WIN_POINTS);
  localparam tick_cnt_t SERVE_LAST = tick_cnt_t'(SERVE_DELAY - 1);
  localparam tick_cnt_t POINT_LAST = tick_cnt_t'(POINT_HOLD - 1);

  logic       start_evt;

  state_t     state_reg;
  tick_cnt_t  tick_cnt_reg;
  logic       run_reg;
  logic       serve_reg;
  logic       serve_dir_reg;
  score_t     score1_reg;
  score_t     score2_reg;
  logic [1:0] winner_reg;

  key_edge u_start_key (
    .clk   (CLOCK_50),
    .rst_n (rst_n),
    .key_n (bus.start_n),
    .fall  (start_evt)
  );

  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      tick_cnt_reg  <= '0;
      run_reg       <= 1'b0;
      serve_reg     <= 1'b0;
      serve_dir_reg <= 1'b0;
      score1_reg    <= '0;
      score2_reg    <= '0;
      winner_reg    <= WINNER_NONE;
    end else begin
      serve_reg <= 1'b0;
      case (state_reg)
        ST_IDLE, ST_OVER: begin
          if (start_evt) begin
            state_reg     <= ST_SERVE;
            tick_cnt_reg  <= '0;
            score1_reg    <= '0;
            score2_reg    <= '0;
            winner_reg    <= WINNER_NONE;
            serve_dir_reg <= bus.dir_rand;
            run_reg       <= 1'b0;
          end
        end

        // Misses are deliberately not looked at here, including on the
        // release cycle itself.
        ST_SERVE: begin
          if (bus.tick) begin
            if (tick_cnt_reg == SERVE_LAST) begin
              state_reg    <= ST_PLAY;
              tick_cnt_reg <= '0;
              serve_reg    <= 1'b1;
              run_reg      <= 1'b1;
            end else begin
              tick_cnt_reg <= tick_cnt_reg + tick_cnt_t'(1);
            end
          end
        end

        // The loser of a point receives the next serve; a double miss is a let.
        ST_PLAY: begin
          if (bus.miss_l || bus.miss_r) begin
            state_reg    <= ST_POINT;
            tick_cnt_reg <= '0;
            run_reg      <= 1'b0;
            if (bus.miss_l && bus.miss_r) begin
              serve_dir_reg <= bus.dir_rand;
            end else if (bus.miss_r) begin
              score1_reg    <= score_inc(score1_reg, WIN_SCORE);
              serve_dir_reg <= 1'b1;
            end else begin
              score2_reg    <= score_inc(score2_reg, WIN_SCORE);
              serve_dir_reg <= 1'b0;
            end
          end
        end

        ST_POINT: begin
          if (bus.tick) begin
            if (tick_cnt_reg == POINT_LAST) begin
              tick_cnt_reg <= '0;
              if (score1_reg == WIN_SCORE || score2_reg == WIN_SCORE) begin
                state_reg  <= ST_OVER;
                winner_reg <= winner_code(score1_reg, score2_reg, WIN_SCORE);
              end else begin
                state_reg <= ST_SERVE;
              end
            end else begin
              tick_cnt_reg <= tick_cnt_reg + tick_cnt_t'(1);
            end
          end
        end

        default: begin
          state_reg    <= ST_IDLE;
          tick_cnt_reg <= '0;
          run_reg      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.run       = run_reg;
  assign bus.serve     = serve_reg;
  assign bus.serve_dir = serve_dir_reg;
  assign bus.score1    = score1_reg;
  assign bus.score2    = score2_reg;
  assign bus.winner    = winner_reg;
  assign bus.state     = state_reg;

endmodule

// File: tb/tb_match_ctrl.sv
// Directed bench for match_ctrl with WIN_POINTS=3, POINT_HOLD=2, SERVE_DELAY=1.
module tb_match_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  match_ctrl_if bus ();

  match_ctrl #(
    .WIN_POINTS  (3),
    .POINT_HOLD  (2),
    .SERVE_DELAY (1)
  ) dut (
    .CLOCK_50 (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    bus.tick = 1'b1;
    step();
    bus.tick = 1'b0;
  endtask

  // Press start and return the number of cycles until SERVE (-1 on timeout).
  task automatic press_start(output int lat);
    lat = -1;
    bus.start_n = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (bus.state == 3'd1) begin
        lat = i;
        break;
      end
    end
    bus.start_n = 1'b1;
    repeat (3) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start_n = 1'b1;
    repeat (2) step();
    checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", bus.state); end
    checks++; if (bus.run !== 1'b0 || bus.serve !== 1'b0 || bus.serve_dir !== 1'b0) begin errors++; $display("FAIL reset_ctl: got run=%b serve=%b dir=%b want 0 0 0", bus.run, bus.serve, bus.serve_dir); end
    checks++; if (bus.score1 !== 4'd0 || bus.score2 !== 4'd0 || bus.winner !== 2'b00) begin errors++; $display("FAIL reset_score: got %0d %0d w=%b want 0 0 00", bus.score1, bus.score2, bus.winner); end
    rst_n = 1'b1;
    repeat (3) step();
    checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL idle_hold: got %0d want 0", bus.state); end
    $display("reset: state=%0d scores=%0d/%0d", bus.state, bus.score1, bus.score2);
  endtask

  task automatic test_start_serve();
    int lat;
    bus.dir_rand = 1'b1;
    press_start(lat);
    checks++; if (lat < 1 || lat > 3) begin errors++; $display("FAIL start_latency: got %0d want 1..3", lat); end
    checks++; if (bus.state !== 3'd1 || bus.serve_dir !== 1'b1 || bus.run !== 1'b0) begin errors++; $display("FAIL start_serve: got st=%0d dir=%b run=%b want 1 1 0", bus.state, bus.serve_dir, bus.run); end
    bus.tick = 1'b1;
    step();
    bus.tick = 1'b0;
    checks++; if (bus.state !== 3'd2 || bus.serve !== 1'b1 || bus.run !== 1'b1) begin errors++; $display("FAIL serve_pulse: got st=%0d serve=%b run=%b want 2 1 1", bus.state, bus.serve, bus.run); end
    step();
    checks++; if (bus.serve !== 1'b0 || bus.run !== 1'b1) begin errors++; $display("FAIL serve_once: got serve=%b run=%b want 0 1", bus.serve, bus.run); end
    $display("start_serve: latency=%0d state=%0d run=%b", lat, bus.state, bus.run);
  endtask

  task automatic test_point_right();
    bus.miss_r = 1'b1;
    step();
    bus.miss_r = 1'b0;
    checks++; if (bus.state !== 3'd3 || bus.score1 !== 4'd1 || bus.score2 !== 4'd0) begin errors++; $display("FAIL miss_r_point: got st=%0d s1=%0d s2=%0d want 3 1 0", bus.state, bus.score1, bus.score2); end
    checks++; if (bus.serve_dir !== 1'b1 || bus.run !== 1'b0) begin errors++; $display("FAIL miss_r_dir: got dir=%b run=%b want 1 0", bus.serve_dir, bus.run); end
    do_tick();
    checks++; if (bus.state !== 3'd3) begin errors++; $display("FAIL point_hold1: got %0d want 3", bus.state); end
    do_tick();
    checks++; if (bus.state !== 3'd1) begin errors++; $display("FAIL point_to_serve: got %0d want 1", bus.state); end
    do_tick();
    checks++; if (bus.state !== 3'd2) begin errors++; $display("FAIL reserve_play: got %0d want 2", bus.state); end
    $display("point_right: s1=%0d dir=%b state=%0d", bus.score1, bus.serve_dir, bus.state);
  endtask

  task automatic test_let();
    bus.dir_rand = 1'b0;
    bus.miss_l = 1'b1;
    bus.miss_r = 1'b1;
    step();
    bus.miss_l = 1'b0;
    bus.miss_r = 1'b0;
    checks++; if (bus.state !== 3'd3 || bus.score1 !== 4'd1 || bus.score2 !== 4'd0) begin errors++; $display("FAIL let_scores: got st=%0d s1=%0d s2=%0d want 3 1 0", bus.state, bus.score1, bus.score2); end
    checks++; if (bus.serve_dir !== 1'b0) begin errors++; $display("FAIL let_dir: got %b want 0", bus.serve_dir); end
    repeat (3) do_tick();
    checks++; if (bus.state !== 3'd2) begin errors++; $display("FAIL let_replay: got %0d want 2", bus.state); end
    $display("let: s1=%0d s2=%0d dir=%b", bus.score1, bus.score2, bus.serve_dir);
  endtask

  task automatic test_win();
    for (int r = 1; r <= 3; r++) begin
      bus.miss_l = 1'b1;
      step();
      bus.miss_l = 1'b0;
      checks++; if (bus.score2 !== 4'(r) || bus.serve_dir !== 1'b0) begin errors++; $display("FAIL rally_%0d: got s2=%0d dir=%b want %0d 0", r, bus.score2, bus.serve_dir, r); end
      do_tick();
      do_tick();
      if (r < 3) begin
        checks++; if (bus.state !== 3'd1 || bus.winner !== 2'b00) begin errors++; $display("FAIL rally_%0d_serve: got st=%0d w=%b want 1 00", r, bus.state, bus.winner); end
        do_tick();
      end
      $display("win rally %0d: s2=%0d state=%0d", r, bus.score2, bus.state);
    end
    checks++; if (bus.state !== 3'd4 || bus.winner !== 2'b10 || bus.run !== 1'b0) begin errors++; $display("FAIL game_over: got st=%0d w=%b run=%b want 4 10 0", bus.state, bus.winner, bus.run); end
    bus.miss_l = 1'b1;
    bus.tick = 1'b1;
    step();
    bus.miss_l = 1'b0;
    bus.tick = 1'b0;
    checks++; if (bus.score2 !== 4'd3 || bus.state !== 3'd4 || bus.winner !== 2'b10) begin errors++; $display("FAIL over_ignore: got s2=%0d st=%0d w=%b want 3 4 10", bus.score2, bus.state, bus.winner); end
  endtask

  task automatic test_restart();
    int lat;
    bus.dir_rand = 1'b0;
    press_start(lat);
    checks++; if (lat < 1 || bus.state !== 3'd1 || bus.winner !== 2'b00) begin errors++; $display("FAIL restart: got lat=%0d st=%0d w=%b want >0 1 00", lat, bus.state, bus.winner); end
    checks++; if (bus.score1 !== 4'd0 || bus.score2 !== 4'd0 || bus.serve_dir !== 1'b0) begin errors++; $display("FAIL restart_clear: got %0d %0d dir=%b want 0 0 0", bus.score1, bus.score2, bus.serve_dir); end
    bus.miss_l = 1'b1; bus.miss_r = 1'b1;
    step();
    bus.miss_l = 1'b0; bus.miss_r = 1'b0;
    checks++; if (bus.state !== 3'd1 || bus.score1 !== 4'd0 || bus.score2 !== 4'd0) begin errors++; $display("FAIL serve_miss: got st=%0d %0d %0d want 1 0 0", bus.state, bus.score1, bus.score2); end
    do_tick();
    bus.miss_r = 1'b1;
    step();
    bus.miss_r = 1'b0;
    bus.miss_l = 1'b1;
    step();
    bus.miss_l = 1'b0;
    checks++; if (bus.state !== 3'd3 || bus.score1 !== 4'd1 || bus.score2 !== 4'd0) begin errors++; $display("FAIL point_miss: got st=%0d %0d %0d want 3 1 0", bus.state, bus.score1, bus.score2); end
    do_tick();
    do_tick();
    bus.miss_r = 1'b1;
    bus.tick = 1'b1;
    step();
    bus.miss_r = 1'b0;
    bus.tick = 1'b0;
    checks++; if (bus.state !== 3'd2 || bus.score1 !== 4'd1) begin errors++; $display("FAIL release_miss: got st=%0d s1=%0d want 2 1", bus.state, bus.score1); end
    $display("restart: state=%0d s1=%0d s2=%0d", bus.state, bus.score1, bus.score2);
  endtask

  task automatic test_reset_mid();
    int lat;
    bus.miss_r = 1'b1;
    step();
    bus.miss_r = 1'b0;
    repeat (3) do_tick();
    checks++; if (bus.state !== 3'd2 || bus.score1 !== 4'd2) begin errors++; $display("FAIL pre_reset: got st=%0d s1=%0d want 2 2", bus.state, bus.score1); end
    rst_n = 1'b0;
    bus.start_n = 1'b0;
    bus.miss_r = 1'b1;
    step();
    bus.miss_r = 1'b0;
    checks++; if (bus.state !== 3'd0 || bus.run !== 1'b0 || bus.serve !== 1'b0 || bus.serve_dir !== 1'b0) begin errors++; $display("FAIL mid_reset_ctl: got st=%0d run=%b serve=%b dir=%b want 0 0 0 0", bus.state, bus.run, bus.serve, bus.serve_dir); end
    checks++; if (bus.score1 !== 4'd0 || bus.score2 !== 4'd0 || bus.winner !== 2'b00) begin errors++; $display("FAIL mid_reset_score: got %0d %0d w=%b want 0 0 00", bus.score1, bus.score2, bus.winner); end
    rst_n = 1'b1;
    repeat (8) step();
    checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL held_start: got %0d want 0", bus.state); end
    bus.start_n = 1'b1;
    repeat (3) step();
    press_start(lat);
    checks++; if (lat < 1 || lat > 3) begin errors++; $display("FAIL repress: got lat=%0d want 1..3", lat); end
    $display("reset_mid: latency=%0d state=%0d", lat, bus.state);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.tick = 1'b0;
    bus.start_n = 1'b1;
    bus.dir_rand = 1'b0;
    bus.miss_l = 1'b0;
    bus.miss_r = 1'b0;
    test_reset();
    test_start_serve();
    test_point_right();
    test_let();
    test_win();
    test_restart();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
